serial_word_comparator: RTL and testbench

Multi-cycle magnitude comparator controller. It compares two WIDTH-bit words by stepping a 2-bit equal/less/greater slice across them, most significant digit first, and stops at the first digit that differs. It sits beside the combinational comparator slices as their sequencer. Higher-level blocks use it when a full-width parallel comparator is too large. Results are returned through a start/done handshake.

---
 rtl/serial_word_comparator.sv | 140 ++++++++++++++
 tb/tb_serial_word_comparator.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_comparator
// Purpose  : Multi-cycle unsigned magnitude comparator. Walks two WIDTH-bit
//            words one 2-bit digit per cycle, most significant digit first.
//            It stops at the first digit that differs and reports eq/lt/gt
//            plus the number of digits it examined.
// Ports    : clk   - rising-edge clock
//            rst   - synchronous active-high reset
//            start - request a comparison (accepted only while idle)
//            a, b  - operands, captured on the accepting edge only
//            busy  - high while a comparison is running or completing
//            done  - one-cycle completion pulse
//            eq/lt/gt - result of the last completed comparison
//            ndig  - digits examined by the last completed comparison
// Revision : 1.0  initial release
// ============================================================================
module serial_word_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  output logic                            busy,
  output logic                            done,
  output logic                            eq,
  output logic                            lt,
  output logic                            gt,
  output logic [$clog2(WIDTH/2+1)-1:0]    ndig
);

  localparam int NDIG = WIDTH / 2;
  localparam int NW   = $clog2(NDIG + 1);
  // Digit index needs at least one bit even when there is a single digit.
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  ra_q, ra_d;
  logic [WIDTH-1:0]  rb_q, rb_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;
  logic              gt_q, gt_d;
  logic [NW-1:0]     ndig_q, ndig_d;

  // Current digit of each captured operand; bit offset is 2*idx.
  logic [1:0]        dig_a;
  logic [1:0]        dig_b;

  assign dig_a = ra_q[{idx_q, 1'b0} +: 2];
  assign dig_b = rb_q[{idx_q, 1'b0} +: 2];

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    ndig_d  = ndig_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = IW'(NDIG - 1);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (dig_a != dig_b) begin
          // First differing digit decides; digits examined = NDIG - idx.
          eq_d    = 1'b0;
          lt_d    = (dig_a < dig_b);
          gt_d    = (dig_a > dig_b);
          ndig_d  = NW'(NDIG) - NW'(idx_q);
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          ndig_d  = NW'(NDIG);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      ndig_q  <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      ndig_q  <= ndig_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign ndig = ndig_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_comparator
// Purpose  : Self-checking bench for serial_word_comparator at WIDTH = 2, 8
//            and 16. Expected results come from a digit-walk reference model
//            and travel through a scoreboard queue from launch to done.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_word_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH = 8 instance
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, eq8, lt8, gt8;
  logic [2:0]  nd8;
  // WIDTH = 2 instance
  logic        start2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, eq2, lt2, gt2;
  logic [0:0]  nd2;
  // WIDTH = 16 instance
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, eq16, lt16, gt16;
  logic [3:0]  nd16;

  serial_word_comparator #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .eq(eq8), .lt(lt8), .gt(gt8), .ndig(nd8)
  );
  serial_word_comparator #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .eq(eq2), .lt(lt2), .gt(gt2), .ndig(nd2)
  );
  serial_word_comparator #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .eq(eq16), .lt(lt16), .gt(gt16), .ndig(nd16)
  );

  typedef struct {
    bit eq;
    bit lt;
    bit gt;
    int nd;
    int acc;   // negedge count at which start was presented to an idle DUT
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(negedge clk) cyc++;

  // Reference: walk digits from the MSB, stop at the first difference.
  function automatic exp_t ref_cmp(input logic [15:0] x, input logic [15:0] y, input int w);
    exp_t r;
    int   xd, yd;
    r.eq = 1'b1; r.lt = 1'b0; r.gt = 1'b0; r.nd = w / 2; r.acc = 0;
    for (int d = w / 2 - 1; d >= 0; d--) begin
      xd = int'((x >> (2 * d)) & 16'h3);
      yd = int'((y >> (2 * d)) & 16'h3);
      if (xd != yd) begin
        r.eq = 1'b0;
        r.lt = (xd < yd);
        r.gt = (xd > yd);
        r.nd = w / 2 - d;
        return r;
      end
    end
    return r;
  endfunction

  function automatic bit dut_done(input int sel);
    case (sel)
      2:       return done2;
      16:      return done16;
      default: return done8;
    endcase
  endfunction

  function automatic bit dut_busy(input int sel);
    case (sel)
      2:       return busy2;
      16:      return busy16;
      default: return busy8;
    endcase
  endfunction

  // Packs the result outputs into the same shape as the model.
  function automatic exp_t dut_res(input int sel);
    exp_t r;
    r.acc = 0;
    case (sel)
      2:       begin r.eq = eq2;  r.lt = lt2;  r.gt = gt2;  r.nd = int'(nd2);  end
      16:      begin r.eq = eq16; r.lt = lt16; r.gt = gt16; r.nd = int'(nd16); end
      default: begin r.eq = eq8;  r.lt = lt8;  r.gt = gt8;  r.nd = int'(nd8);  end
    endcase
    return r;
  endfunction

  task automatic drive(input int sel, input bit s, input logic [15:0] x, input logic [15:0] y);
    case (sel)
      2:       begin start2  = s; a2  = x[1:0]; b2  = y[1:0]; end
      16:      begin start16 = s; a16 = x;      b16 = y;      end
      default: begin start8  = s; a8  = x[7:0]; b8  = y[7:0]; end
    endcase
  endtask

  // Presents start for one edge and records the expected result.
  task automatic launch(input int sel, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    @(negedge clk);
    drive(sel, 1'b1, x, y);
    e = ref_cmp(x, y, sel);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    drive(sel, 1'b0, x, y);
  endtask

  // Called on the first negedge after acceptance. n counts negedges after
  // acceptance up to and including the done one; bc counts those with busy.
  task automatic wait_done(input int sel, output int n, output int bc);
    n  = 1;
    bc = dut_busy(sel) ? 1 : 0;
    while (!dut_done(sel) && n < 40) begin
      @(negedge clk);
      n++;
      if (dut_busy(sel)) bc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done8); end
    total++; if ({eq8, lt8, gt8} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {eq8, lt8, gt8}); end
    total++; if (nd8 !== 3'd0) begin bad++; $display("FAIL reset_ndig got=%0d want=0", nd8); end
    total++; if ({busy2, busy16, done2, done16} !== 4'b0000) begin bad++; $display("FAIL reset_other got=%b want=0000", {busy2, busy16, done2, done16}); end
    rst = 1'b0;
  endtask

  // Single comparison with full checking of result, latency and busy span.
  task automatic test_compare(input string name, input int sel, input logic [15:0] x, input logic [15:0] y);
    int   n, bc;
    exp_t e, g;
    launch(sel, x, y);
    wait_done(sel, n, bc);
    e = sb.pop_front();
    g = dut_res(sel);
    total++;
    if (!dut_done(sel)) begin
      bad++; $display("FAIL %s_timeout no done after %0d cycles", name, n);
    end else if ({g.eq, g.lt, g.gt} !== {e.eq, e.lt, e.gt} || g.nd != e.nd) begin
      bad++; $display("FAIL %s_result got eq/lt/gt=%b%b%b ndig=%0d want %b%b%b ndig=%0d",
                      name, g.eq, g.lt, g.gt, g.nd, e.eq, e.lt, e.gt, e.nd);
    end
    total++; if (n - 1 != e.nd) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, n - 1, e.nd); end
    total++; if (bc != e.nd + 1) begin bad++; $display("FAIL %s_busy_span got=%0d want=%0d", name, bc, e.nd + 1); end
    @(negedge clk);
    total++;
    if (dut_busy(sel) !== 1'b0 || dut_done(sel) !== 1'b0) begin
      bad++; $display("FAIL %s_after_done got busy=%b done=%b want 0 0", name, dut_busy(sel), dut_done(sel));
    end
  endtask

  task automatic test_ignore_busy;
    int   n, bc, extra;
    exp_t e, g;
    launch(8, 16'h0000, 16'h00FF);
    // Now in RUN: a second start with new operands must be ignored.
    drive(8, 1'b1, 16'h00FF, 16'h0000);
    @(negedge clk);
    drive(8, 1'b0, 16'h00AA, 16'h0055);
    n = 2; bc = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    e = sb.pop_front();
    g = dut_res(8);
    total++;
    if (!done8 || {g.eq, g.lt, g.gt} !== {e.eq, e.lt, e.gt} || g.nd != e.nd) begin
      bad++; $display("FAIL ignore_result got done=%b eq/lt/gt=%b%b%b ndig=%0d want 1 %b%b%b ndig=%0d",
                      done8, g.eq, g.lt, g.gt, g.nd, e.eq, e.lt, e.gt, e.nd);
    end
    extra = 0;
    repeat (8) begin @(negedge clk); if (done8) extra++; end
    total++; if (extra != 0) begin bad++; $display("FAIL ignore_extra_done got=%0d want=0", extra); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL ignore_idle got busy=%b want=0", busy8); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    drive(8, 1'b1, 16'h0012, 16'h0012);   // accepted at E0
    @(negedge clk);
    drive(8, 1'b0, 16'h0012, 16'h0012);   // E1 evaluates the first digit
    @(negedge clk);
    rst = 1'b1;                           // sampled at E2
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy8, done8, eq8, lt8, gt8} !== 5'b00000 || nd8 !== 3'd0) begin
      bad++; $display("FAIL midreset_state got busy/done/eq/lt/gt=%b ndig=%0d want 00000 ndig=0",
                      {busy8, done8, eq8, lt8, gt8}, nd8);
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (done8 || busy8) seen++; end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_quiet got=%0d active cycles want=0", seen); end
    test_compare("post_reset", 8, 16'h00A5, 16'h005A);
  endtask

  // start held high; operands change each time the DUT is idle.
  task automatic test_back_to_back;
    logic [15:0] xs [4] = '{16'h00A5, 16'h0080, 16'h0034, 16'h003C};
    logic [15:0] ys [4] = '{16'h00A5, 16'h007F, 16'h0036, 16'h0034};
    int   pushed, dones, prev_done, guard;
    bit   have;
    exp_t e, g, held;
    pushed = 0; dones = 0; prev_done = -10; guard = 0; have = 1'b0;
    held.eq = 0; held.lt = 0; held.gt = 0; held.nd = 0; held.acc = 0;
    while (dones < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      g = dut_res(8);
      if (done8) begin
        e = sb.pop_front();
        total++;
        if ({g.eq, g.lt, g.gt} !== {e.eq, e.lt, e.gt} || g.nd != e.nd || cyc - e.acc != e.nd + 1) begin
          bad++; $display("FAIL b2b_result%0d got %b%b%b ndig=%0d lat=%0d want %b%b%b ndig=%0d lat=%0d",
                          dones, g.eq, g.lt, g.gt, g.nd, cyc - e.acc - 1, e.eq, e.lt, e.gt, e.nd, e.nd);
        end
        total++; if (cyc - prev_done < 2) begin bad++; $display("FAIL b2b_done_gap got=%0d want>=2", cyc - prev_done); end
        prev_done = cyc;
        held = g;
        have = 1'b1;
        dones++;
      end else if (have) begin
        total++;
        if ({g.eq, g.lt, g.gt} !== {held.eq, held.lt, held.gt} || g.nd != held.nd) begin
          bad++; $display("FAIL b2b_hold got %b%b%b ndig=%0d want %b%b%b ndig=%0d",
                          g.eq, g.lt, g.gt, g.nd, held.eq, held.lt, held.gt, held.nd);
        end
      end
      if (!busy8 && pushed < 4) begin
        drive(8, 1'b1, xs[pushed], ys[pushed]);
        e = ref_cmp(xs[pushed], ys[pushed], 8);
        e.acc = cyc;
        sb.push_back(e);
        pushed++;
      end
    end
    drive(8, 1'b0, 16'h0000, 16'h0000);
    total++; if (dones != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", dones); end
    @(negedge clk);
  endtask

  task automatic test_width;
    test_compare("w2_equal",  2,  16'h0002, 16'h0002);
    test_compare("w2_less",   2,  16'h0001, 16'h0003);
    test_compare("w16_equal", 16, 16'hBEEF, 16'hBEEF);
    test_compare("w16_mid",   16, 16'h1234, 16'h1134);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_compare("equal",     8, 16'h00A5, 16'h00A5);
    test_compare("msb_exit",  8, 16'h0080, 16'h007F);
    test_compare("lsb_lt",    8, 16'h0034, 16'h0036);
    test_compare("third_gt",  8, 16'h003C, 16'h0034);
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
